// File: rtl/gts_pkg.sv
// Shared types, widths and the tap-location arithmetic for the global tap scheduler.
package gts_pkg;

    localparam int N_SAMPLE         = 256;
    localparam int SAMPLE_ADDR_W    = $clog2(N_SAMPLE);
    localparam int ID_W             = 4;
    localparam int DELAY_W          = ID_W + SAMPLE_ADDR_W;
    localparam int N_OBJ_DEF        = 8;
    localparam int OBJ_ID_W         = 3;
    localparam int N_LAT_DEF        = 2;
    localparam int PREFETCH_LEN_DEF = 16;

    typedef enum logic [1:0] {IDLE, LOAD, PARSE, BCAST} state_t;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [DELAY_W-1:0]  eff;
        logic [OBJ_ID_W-1:0] obj_id;
    } entry_t;

    // Tap sits "delay + latency" samples behind the write head on the circular span.
    function automatic logic [DELAY_W-1:0] calc_eff(input logic [DELAY_W-1:0] delay,
                                                    input logic [DELAY_W-1:0] lat);
        return {DELAY_W{1'b0}} - delay - lat;
    endfunction

endpackage

// File: rtl/gts_delay_table.sv
// Double-buffered delay table: writes land in the shadow copy, commit copies shadow to active.
module gts_delay_table
    import gts_pkg::*;
#(
    parameter int N_OBJ = N_OBJ_DEF
)(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [OBJ_ID_W-1:0] wr_idx_i,
    input  logic [DELAY_W-1:0]  wr_eff_i,
    input  logic                commit_i,
    input  logic [OBJ_ID_W-1:0] rd_idx_i,
    output entry_t              rd_entry_o,
    input  logic                clr_en_i,
    input  logic [OBJ_ID_W-1:0] clr_idx_i,
    output logic                any_dirty_o
);

    localparam logic [OBJ_ID_W:0] N_OBJ_L = (OBJ_ID_W+1)'(N_OBJ);

    entry_t shadow_q [N_OBJ];
    entry_t active_q [N_OBJ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (commit_i)
                    active_q[i] <= shadow_q[i];
                else if (clr_en_i && clr_idx_i == OBJ_ID_W'(i))
                    active_q[i].dirty <= 1'b0;

                // Dirty is mirrored in shadow so the PARSE exit sees acknowledged entries as clean.
                if (wr_en_i && wr_idx_i == OBJ_ID_W'(i))
                    shadow_q[i] <= '{valid: 1'b1, dirty: 1'b1, eff: wr_eff_i, obj_id: wr_idx_i};
                else if (clr_en_i && clr_idx_i == OBJ_ID_W'(i))
                    shadow_q[i].dirty <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_entry_o = '0;
        if ({1'b0, rd_idx_i} < N_OBJ_L)
            rd_entry_o = active_q[rd_idx_i];
    end

    always_comb begin
        any_dirty_o = 1'b0;
        for (int i = 0; i < N_OBJ; i++)
            any_dirty_o = any_dirty_o | shadow_q[i].dirty;
    end

endmodule

// File: rtl/global_tap_scheduler.sv
// Global tap scheduler: loads the per-object delay table and broadcasts tap/prefetch
// packets to the local controllers over a valid/ready handshake.
//
// state | meaning
// IDLE  | no table activity, writes refused
// LOAD  | boot-time full table load
// PARSE | incremental updates, committed by scenario_update
// BCAST | commit then scan table, emitting packets
module global_tap_scheduler
    import gts_pkg::*;
#(
    parameter int N_OBJ        = N_OBJ_DEF,
    parameter int N_LAT        = N_LAT_DEF,
    parameter int PREFETCH_LEN = PREFETCH_LEN_DEF
)(
    input  logic                                   CLK,
    input  logic                                   reset,
    input  logic                                   boot_up,
    input  logic                                   table_parse,
    input  logic                                   scenario_update,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [DELAY_W-1:0]                     delay_matrix_element,
    input  logic [OBJ_ID_W-1:0]                    obj_id_element,
    input  logic [((N_LAT > 1) ? $clog2(N_LAT) : 1)-1:0] lat_sel,
    input  logic [N_LAT*DELAY_W-1:0]               hardware_latency,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ID_W-1:0]                        local_controller_id,
    output logic [SAMPLE_ADDR_W+OBJ_ID_W-1:0]      tapping_loc_packet,
    output logic [SAMPLE_ADDR_W-1:0]               from_glob_prefetch_start,
    output logic [SAMPLE_ADDR_W-1:0]               from_glob_prefetch_stop,
    output logic [ID_W-1:0]                        from_glob_prefetch_dest,
    output logic                                   busy,
    output logic                                   err_flag
);

    localparam logic [OBJ_ID_W:0] N_OBJ_L = (OBJ_ID_W+1)'(N_OBJ);

    state_t                   state_q, state_d;
    logic                     full_mode_q, pending_q, commit_q, err_q;
    logic [OBJ_ID_W:0]        ptr_q;
    logic                     out_valid_q;
    logic [ID_W-1:0]          out_id_q;
    logic [SAMPLE_ADDR_W-1:0] out_addr_q, out_stop_q;
    logic [OBJ_ID_W-1:0]      out_obj_q;

    entry_t             rd_entry;
    logic               any_dirty, wr_req, obj_ok, wr_en;
    logic [DELAY_W-1:0] lat_val, wr_eff;
    logic               scan_active, slot_free, emit, beat_done, scan_done, restart, start_bcast;

    assign wr_req      = cfg_valid && cfg_ready;
    assign obj_ok      = {1'b0, obj_id_element} < N_OBJ_L;
    assign wr_en       = wr_req && obj_ok;
    assign lat_val     = hardware_latency[int'(lat_sel)*DELAY_W +: DELAY_W];
    assign wr_eff      = calc_eff(delay_matrix_element, lat_val);

    // commit_q holds off the scan for the cycle in which shadow is copied into active.
    assign scan_active = (state_q == BCAST) && !commit_q && (ptr_q != N_OBJ_L);
    assign slot_free   = !out_valid_q || out_ready;
    assign emit        = scan_active && slot_free && rd_entry.valid && (full_mode_q || rd_entry.dirty);
    assign beat_done   = out_valid_q && out_ready;
    assign scan_done   = (state_q == BCAST) && !commit_q && (ptr_q == N_OBJ_L) && slot_free;
    assign restart     = scan_done && (pending_q || scenario_update);
    assign start_bcast = ((state_q == LOAD) && !boot_up) || ((state_q == PARSE) && scenario_update);

    gts_delay_table #(.N_OBJ(N_OBJ)) u_table (
        .clk_i      (CLK),
        .rst_i      (reset),
        .wr_en_i    (wr_en),
        .wr_idx_i   (obj_id_element),
        .wr_eff_i   (wr_eff),
        .commit_i   (commit_q),
        .rd_idx_i   (ptr_q[OBJ_ID_W-1:0]),
        .rd_entry_o (rd_entry),
        .clr_en_i   (beat_done),
        .clr_idx_i  (out_obj_q),
        .any_dirty_o(any_dirty)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (boot_up) state_d = LOAD;
                   else if (table_parse) state_d = PARSE;
            LOAD:  if (!boot_up) state_d = BCAST;
            PARSE: if (scenario_update) state_d = BCAST;
                   else if (!table_parse && !any_dirty) state_d = IDLE;
            BCAST: if (scan_done && !restart) state_d = table_parse ? PARSE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == LOAD) || (state_q == PARSE);
        busy      = (state_q == BCAST) || pending_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            full_mode_q <= 1'b0;
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_addr_q  <= '0;
            out_stop_q  <= '0;
            out_obj_q   <= '0;
        end else begin
            if (wr_req && !obj_ok) err_q <= 1'b1;
            commit_q <= start_bcast || restart;

            if (start_bcast) begin
                full_mode_q <= (state_q == LOAD);
                ptr_q       <= '0;
            end else if (restart) begin
                full_mode_q <= 1'b0;
                ptr_q       <= '0;
            end else if (scan_active && slot_free) begin
                ptr_q <= ptr_q + (OBJ_ID_W+1)'(1);
            end

            if (restart)                                      pending_q <= 1'b0;
            else if ((state_q == BCAST) && scenario_update)   pending_q <= 1'b1;

            if (emit) begin
                out_valid_q <= 1'b1;
                out_id_q    <= rd_entry.eff[DELAY_W-1:SAMPLE_ADDR_W];
                out_addr_q  <= rd_entry.eff[SAMPLE_ADDR_W-1:0];
                out_stop_q  <= rd_entry.eff[SAMPLE_ADDR_W-1:0] + SAMPLE_ADDR_W'(PREFETCH_LEN-1);
                out_obj_q   <= rd_entry.obj_id;
            end else if (beat_done) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid                = out_valid_q;
    assign local_controller_id      = out_id_q;
    assign tapping_loc_packet       = {out_addr_q, out_obj_q};
    assign from_glob_prefetch_start = out_addr_q;
    assign from_glob_prefetch_stop  = out_stop_q;
    assign from_glob_prefetch_dest  = out_id_q;
    assign err_flag                 = err_q;

endmodule

// File: tb/tb_global_tap_scheduler.sv
// Directed bench for global_tap_scheduler; the table is sized to 6 objects so that
// 3-bit object ids 6 and 7 exercise the out-of-range write path.
module tb_global_tap_scheduler;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        boot_up = 1'b0, table_parse = 1'b0, scenario_update = 1'b0;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [11:0] delay_matrix_element = '0;
    logic [2:0]  obj_id_element = '0;
    logic [0:0]  lat_sel = '0;
    logic [23:0] hardware_latency = {12'd100, 12'd0};
    logic        out_valid, out_ready = 1'b1;
    logic [3:0]  local_controller_id, from_glob_prefetch_dest;
    logic [10:0] tapping_loc_packet;
    logic [7:0]  from_glob_prefetch_start, from_glob_prefetch_stop;
    logic        busy, err_flag;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    global_tap_scheduler #(.N_OBJ(6), .N_LAT(2), .PREFETCH_LEN(16)) dut (
        .CLK                     (CLK),
        .reset                   (reset),
        .boot_up                 (boot_up),
        .table_parse             (table_parse),
        .scenario_update         (scenario_update),
        .cfg_valid               (cfg_valid),
        .cfg_ready               (cfg_ready),
        .delay_matrix_element    (delay_matrix_element),
        .obj_id_element          (obj_id_element),
        .lat_sel                 (lat_sel),
        .hardware_latency        (hardware_latency),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .local_controller_id     (local_controller_id),
        .tapping_loc_packet      (tapping_loc_packet),
        .from_glob_prefetch_start(from_glob_prefetch_start),
        .from_glob_prefetch_stop (from_glob_prefetch_stop),
        .from_glob_prefetch_dest (from_glob_prefetch_dest),
        .busy                    (busy),
        .err_flag                (err_flag)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int delay, input int obj, input int ls);
        delay_matrix_element = 12'(delay);
        obj_id_element       = 3'(obj);
        lat_sel              = 1'(ls);
        cfg_valid            = 1'b1;
        tick();
        cfg_valid            = 1'b0;
    endtask

    // Waits (bounded) for a beat, checks all packet fields, then lets it be accepted.
    task automatic expect_beat(input string tag, input int id, input int addr, input int obj);
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".id"},    32'(local_controller_id), 32'(id));
        chk({tag, ".pkt"},   32'(tapping_loc_packet), 32'(addr * 8 + obj));
        chk({tag, ".start"}, 32'(from_glob_prefetch_start), 32'(addr));
        chk({tag, ".stop"},  32'(from_glob_prefetch_stop), 32'((addr + 15) % 256));
        chk({tag, ".dest"},  32'(from_glob_prefetch_dest), 32'(id));
        tick();
    endtask

    task automatic drain(input string tag, input int exp_beats);
        int n = 0;
        int k = 0;
        while (busy && k < 60) begin
            if (out_valid) n++;
            tick();
            k++;
        end
        chk({tag, ".beats"}, 32'(n), 32'(exp_beats));
        chk({tag, ".idle"},  32'(busy), 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.ready", 32'(cfg_ready), 0);
        chk("rst.id",    32'(local_controller_id), 0);
        chk("rst.pkt",   32'(tapping_loc_packet), 0);
        chk("rst.start", 32'(from_glob_prefetch_start), 0);
        chk("rst.stop",  32'(from_glob_prefetch_stop), 0);
        chk("rst.dest",  32'(from_glob_prefetch_dest), 0);
        chk("rst.busy",  32'(busy), 0);
        chk("rst.err",   32'(err_flag), 0);
        reset = 1'b0;
        tick();

        // 1. Boot load and full broadcast, including first-beat latency
        boot_up = 1'b1;
        tick();
        chk("boot.ready", 32'(cfg_ready), 1);
        cfg_write(400, 1, 0);
        cfg_write(500, 0, 0);
        cfg_write(850, 2, 0);
        boot_up = 1'b0;
        tick();
        chk("boot.lat1", 32'(out_valid), 0);
        chk("boot.busy", 32'(busy), 1);
        chk("boot.nordy", 32'(cfg_ready), 0);
        tick();
        chk("boot.lat2", 32'(out_valid), 0);
        tick();
        chk("boot.lat3", 32'(out_valid), 1);
        expect_beat("boot.o0", 14, 12, 0);
        expect_beat("boot.o1", 14, 112, 1);
        expect_beat("boot.o2", 12, 174, 2);
        drain("boot", 0);

        // 2. Incremental update: only dirty entries re-sent
        table_parse = 1'b1;
        tick();
        cfg_write(401, 1, 0);
        cfg_write(510, 0, 0);
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        expect_beat("parse.o0", 14, 2, 0);
        expect_beat("parse.o1", 14, 111, 1);
        drain("parse", 0);
        chk("parse.back", 32'(cfg_ready), 1);
        table_parse = 1'b0;
        tick();
        chk("parse.idle", 32'(cfg_ready), 0);

        // 3. Latency register 1 (100) applied to a boot write
        boot_up = 1'b1;
        tick();
        cfg_write(400, 3, 1);
        boot_up = 1'b0;
        expect_beat("lat.o0", 14, 2, 0);
        expect_beat("lat.o1", 14, 111, 1);
        expect_beat("lat.o2", 12, 174, 2);
        expect_beat("lat.o3", 14, 12, 3);
        drain("lat", 0);

        // 4. Backpressure hold and stop wrap (250 -> 9)
        table_parse = 1'b1;
        tick();
        cfg_write(6, 4, 0);
        out_ready = 1'b0;
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(out_valid), 1);
            chk("bp.id",    32'(local_controller_id), 15);
            chk("bp.start", 32'(from_glob_prefetch_start), 250);
            chk("bp.stop",  32'(from_glob_prefetch_stop), 9);
            chk("bp.pkt",   32'(tapping_loc_packet), 2004);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp.done", 32'(out_valid), 0);
        drain("bp", 0);
        table_parse = 1'b0;
        tick();

        // 5a. Out-of-range object id is dropped and flagged
        table_parse = 1'b1;
        tick();
        chk("err.pre", 32'(err_flag), 0);
        cfg_write(123, 6, 0);
        chk("err.flag", 32'(err_flag), 1);
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        drain("err", 0);

        // 5b. scenario_update mid-broadcast queues a second dirty broadcast
        cfg_write(20, 5, 0);
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        tick();
        scenario_update = 1'b1;
        tick();
        scenario_update = 1'b0;
        expect_beat("pend.o5", 15, 236, 5);
        chk("pend.busy", 32'(busy), 1);
        drain("pend", 0);
        chk("pend.err", 32'(err_flag), 1);
        table_parse = 1'b0;
        tick();

        // 5c. Reset mid-broadcast aborts and empties the tables
        boot_up = 1'b1;
        tick();
        boot_up = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("rmid.valid", 32'(out_valid), 1);
        reset = 1'b1;
        tick();
        chk("rmid.valid0", 32'(out_valid), 0);
        chk("rmid.busy",   32'(busy), 0);
        chk("rmid.err",    32'(err_flag), 0);
        chk("rmid.stop",   32'(from_glob_prefetch_stop), 0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        boot_up = 1'b1;
        tick();
        boot_up = 1'b0;
        tick();
        chk("empty.busy", 32'(busy), 1);
        drain("empty", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
